hub_fold_seq: RTL and testbench
===============================

# hub_fold_seq

Control sequencer that issues the `load` / `sel` / `clear` / `part` control stream to a folded HUB linear layer (the FC fold datapath) and sequences one inference job through all fold partitions. It accepts a job from the upstream network controller with a valid/ready start handshake, clears the layer's accumulators, and walks `part` from 0 to FOLD-1. Each partition gets a load pulse followed by CLEN bitstream cycles. When the job completes, the sequencer presents a result-valid handshake to the downstream consumer of `oFmap`.

## Interface
- FOLD, 2, number of fold partitions; legal range ≥1
- PWID, (clog2(FOLD)<2 ? 1 : clog2(FOLD)), width of `part`
- CLEN, 256, bitstream cycles per partition; legal range ≥1
- CWID, clog2(CLEN+1), width of the run counter
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  job request
- sel_i  in  1  input-source select for the job; latched on accept
- i_ready  out  1  sequencer idle and able to accept `start`
- hold  in  1  stall of upstream bitstream sources; freezes the RUN counter
- abort  in  1  cancel the current job
- load  out  1  load pulse to the fold layer
- clear  out  1  accumulator clear pulse to the fold layer
- sel  out  1  latched `sel_i`
- part  out  PWID  active partition index
- run  out  1  a bitstream cycle is being consumed (RUN and not `hold`)
- o_valid  out  1  result on `oFmap` is complete
- o_ready  in  1  downstream has taken the result

## Operation
- States: IDLE, CLEAR, LOAD, RUN, DONE. All outputs except `i_ready` and `run` are registered.
- IDLE: `i_ready`=1. A `start` sampled high moves the sequencer to CLEAR, latches `sel_i` into `sel`, and sets `part`=0.
- CLEAR: `clear`=1 for exactly 1 cycle, then LOAD.
- LOAD: `load`=1 for exactly 1 cycle. `hold` is ignored in this state. The counter is set to 0 and the sequencer moves to RUN.
- RUN: the counter increments on each cycle with `hold`=0.
  - When the counter reaches CLEN-1 and `hold`=0: if `part`==FOLD-1, go to DONE; otherwise increment `part` and go to LOAD.
- DONE: `o_valid`=1 and is held until `o_ready` is sampled high; the sequencer then goes to IDLE. `part` and `sel` keep their values until the next accept.
- Outputs `part` and `sel` change only on accept or on partition advance, never mid-partition.
- Arithmetic: the counter is unsigned CWID bits and never wraps. `part` never exceeds FOLD-1. With FOLD=1, `part` stays 0.
- abort: from any non-IDLE state, the next state is IDLE with `load`=`clear`=`o_valid`=0. `abort` in IDLE has no effect. `abort` has priority over `o_ready` and over counter completion.
- `start` while not in IDLE is ignored and not queued.
- `o_ready` asserted outside DONE is ignored.

## Timing
- Reset values: state IDLE, `load`=0, `clear`=0, `sel`=0, `part`=0, `o_valid`=0, counter 0. `i_ready`=0 and `run`=0 while `rst`=1.
- `rst` mid-job returns to IDLE on the next edge. There is no residual pulse.
- Latency: for an accept in cycle k with no `hold`, CLEAR is cycle k+1 and LOAD of part p is cycle k+2+p·(CLEN+1). `o_valid` first rises in cycle k+2+FOLD·(CLEN+1).
- Each `hold` cycle in RUN adds exactly one cycle of latency.
- `o_valid` high together with `o_ready` high at an edge puts the sequencer in IDLE on the next cycle. A new `start` is accepted in that IDLE cycle at the earliest.

## Configuration
- Macro: `HUB_FOLD_SEQ_PERF_EN`.
- Defined: the block adds output `perf_cyc` [31:0].
  - It is cleared on accept and increments on every non-IDLE, non-DONE cycle.
  - It saturates at 0xFFFFFFFF and holds its value in DONE and IDLE. Reset value is 0.
- Undefined: the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package `hub_fold_pkg`: state enum typedef `fold_state_t` (IDLE, CLEAR, LOAD, RUN, DONE) and the PWID derivation function.
- One sub-module, `hub_run_cnt`: a CWID-bit counter with sync clear and enable, and a terminal-count flag at CLEN-1.

## Test plan
- FOLD=2, CLEN=4, single `start` with `sel_i`=1, `o_ready`=1 → `clear` at k+1; `load` at k+2 (`part`=0) and k+7 (`part`=1); `o_valid` at k+12; `sel`=1 throughout.
- Same configuration, `hold` high for 3 cycles during part 1's RUN → `o_valid` at k+15, and `run` low for those 3 cycles.
- `o_ready` held low for 5 cycles in DONE → `o_valid` stays 1; `start` pulses in that window are ignored; `i_ready` stays 0.
- `abort` in the 2nd RUN cycle of part 1 → IDLE next cycle, `o_valid` never rises. A `start` 1 cycle later is accepted and `part` restarts at 0.
- `rst` asserted during LOAD → next cycle all outputs at their reset values; `i_ready`=1 after `rst` falls.
- FOLD=1, CLEN=1 → `part` always 0, `o_valid` at k+4. With `HUB_FOLD_SEQ_PERF_EN` defined, `perf_cyc`=3.

Source files
------------

// File: rtl/hub_fold_pkg.sv
// Shared types for the folded HUB layer sequencer: state encoding and
// the helper that sizes the partition index.
package hub_fold_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    RUN,
    DONE
  } fold_state_t;

  // Width of the partition index; never narrower than one bit so FOLD=1 still has a port.
  function automatic int part_width(input int fold);
    return ($clog2(fold) < 2) ? 1 : $clog2(fold);
  endfunction

endpackage

// File: rtl/hub_run_cnt.sv
// Bitstream-cycle counter for one fold partition. Cleared while the layer
// is being loaded, advanced on every consumed bitstream cycle, and flags
// the last cycle of the partition. It stops at CLEN rather than wrapping.
module hub_run_cnt #(
  parameter int CLEN = 256,
  parameter int CWID = $clog2(CLEN + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CWID-1:0] cnt;

  // Count consumed cycles; clear has priority over enable, and the count parks at CLEN.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CWID'(CLEN))) begin
      cnt <= cnt + CWID'(1);
    end
  end

  assign tc = (cnt == CWID'(CLEN - 1));

endmodule

// File: rtl/hub_fold_seq.sv
// Control sequencer for a folded HUB linear layer. Accepts one job, clears
// the accumulators, then walks every fold partition with a load pulse
// followed by CLEN bitstream cycles, and finally holds result-valid until
// the consumer takes it. Defining HUB_FOLD_SEQ_PERF_EN adds the perf_cyc
// busy-cycle counter port.
module hub_fold_seq
  import hub_fold_pkg::*;
#(
  parameter int FOLD = 2,
  parameter int PWID = part_width(FOLD),
  parameter int CLEN = 256,
  parameter int CWID = $clog2(CLEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            sel_i,
  output logic            i_ready,
  input  logic            hold,
  input  logic            abort,
  output logic            load,
  output logic            clear,
  output logic            sel,
  output logic [PWID-1:0] part,
  output logic            run,
  output logic            o_valid,
  input  logic            o_ready
`ifdef HUB_FOLD_SEQ_PERF_EN
  ,
  output logic [31:0]     perf_cyc
`endif
);

  fold_state_t state;
  fold_state_t next_state;
  logic        accept;
  logic        last_part;
  logic        cnt_tc;
  logic        part_adv;

  assign accept    = (state == IDLE) && start;
  assign last_part = (part == PWID'(FOLD - 1));
  assign part_adv  = (state == RUN) && (next_state == LOAD);

  // The only unregistered outputs; both are forced low while reset is held.
  assign i_ready = (state == IDLE) && !rst;
  assign run     = (state == RUN) && !hold && !rst;

  hub_run_cnt #(
    .CLEN(CLEN),
    .CWID(CWID)
  ) u_run_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state == LOAD),
    .en ((state == RUN) && !hold),
    .tc (cnt_tc)
  );

  // Next-state selection; abort overrides everything once a job is in flight.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = CLEAR;
      CLEAR:   next_state = LOAD;
      LOAD:    next_state = RUN;
      RUN:     if (!hold && cnt_tc) next_state = last_part ? DONE : LOAD;
      DONE:    if (o_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      next_state = IDLE;
    end
  end

  // State plus registered control outputs, decoded from the state being entered so pulses align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      load    <= 1'b0;
      clear   <= 1'b0;
      o_valid <= 1'b0;
      sel     <= 1'b0;
      part    <= '0;
    end else begin
      state   <= next_state;
      load    <= (next_state == LOAD);
      clear   <= (next_state == CLEAR);
      o_valid <= (next_state == DONE);
      if (accept) begin
        sel  <= sel_i;
        part <= '0;
      end else if (part_adv) begin
        part <= part + PWID'(1);
      end
    end
  end

`ifdef HUB_FOLD_SEQ_PERF_EN
  // Busy-cycle counter: restarts on accept, counts CLEAR/LOAD/RUN cycles, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cyc <= '0;
    end else if (accept) begin
      perf_cyc <= '0;
    end else if ((state inside {CLEAR, LOAD, RUN}) && (perf_cyc != 32'hFFFF_FFFF)) begin
      perf_cyc <= perf_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hub_fold_seq.sv
// Self-checking bench for hub_fold_seq. Instance dut uses FOLD=2, CLEN=4;
// instance dut1 uses FOLD=1, CLEN=1. Job timelines are predicted from a
// schedule built out of the partition/bitstream rules, not from the RTL.
module tb_hub_fold_seq;

  localparam int FOLD_A = 2;
  localparam int CLEN_A = 4;
  localparam int NT     = 128;

  logic clk = 1'b0;
  logic rst, start, start1, sel_i, hold, abort, o_ready;
  logic i_ready, load, clear, sel, run, o_valid;
  logic [0:0] part;
  logic i_ready1, load1, clear1, sel1, run1, o_valid1;
  logic [0:0] part1;
`ifdef HUB_FOLD_SEQ_PERF_EN
  logic [31:0] perf_cyc, perf_cyc1;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Stimulus pattern and predicted timeline for one job on dut.
  bit   hold_arr[NT];
  bit   rdy_arr[NT];
  logic e_clear[NT], e_load[NT], e_ov[NT], e_run[NT], e_ir[NT], e_sel[NT];
  int   e_part[NT];
  int   t_done, t_idle, first_valid;
  logic cur_sel;
  int   cur_part;

  always #5 clk = ~clk;

  hub_fold_seq #(.FOLD(FOLD_A), .CLEN(CLEN_A)) dut (
    .clk(clk), .rst(rst), .start(start), .sel_i(sel_i), .i_ready(i_ready),
    .hold(hold), .abort(abort), .load(load), .clear(clear), .sel(sel),
    .part(part), .run(run), .o_valid(o_valid), .o_ready(o_ready)
`ifdef HUB_FOLD_SEQ_PERF_EN
    , .perf_cyc(perf_cyc)
`endif
  );

  hub_fold_seq #(.FOLD(1), .CLEN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sel_i(sel_i), .i_ready(i_ready1),
    .hold(hold), .abort(abort), .load(load1), .clear(clear1), .sel(sel1),
    .part(part1), .run(run1), .o_valid(o_valid1), .o_ready(o_ready)
`ifdef HUB_FOLD_SEQ_PERF_EN
    , .perf_cyc(perf_cyc1)
`endif
  );

  // Predict the job timeline: clear at 1, then per partition one load cycle
  // followed by as many cycles as it takes to consume CLEN non-held cycles,
  // then valid until the first cycle with o_ready high, then idle.
  task automatic build_model(input logic s);
    int t;
    int consumed;
    for (int i = 0; i < NT; i++) begin
      e_clear[i] = 0; e_load[i] = 0; e_ov[i] = 0; e_run[i] = 0; e_ir[i] = 0;
      e_sel[i] = s; e_part[i] = 0;
    end
    e_ir[0] = 1; e_sel[0] = cur_sel; e_part[0] = cur_part;
    e_clear[1] = 1;
    t = 2;
    for (int p = 0; p < FOLD_A; p++) begin
      e_load[t] = 1; e_part[t] = p; t++;
      consumed = 0;
      while (consumed < CLEN_A && t < 120) begin
        e_part[t] = p;
        e_run[t] = !hold_arr[t];
        if (!hold_arr[t]) consumed++;
        t++;
      end
    end
    t_done = t;
    while (t < NT - 2) begin
      e_ov[t] = 1; e_part[t] = FOLD_A - 1;
      if (rdy_arr[t]) break;
      t++;
    end
    t_idle = t + 1;
    e_ir[t_idle] = 1; e_part[t_idle] = FOLD_A - 1;
  endtask

  // Drive one job on dut following hold_arr/rdy_arr and compare every cycle.
  task automatic run_job(input logic s, input bit busy_start, input bit chain, input logic chain_sel);
    logic [6:0] exp_v, obs_v;
    build_model(s);
    first_valid = -1;
    for (int t = 0; t <= t_idle; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        start = 1; sel_i = s;
      end else if (t < t_idle) begin
        start = busy_start ? 1'b1 : 1'($urandom_range(0, 1));
        sel_i = 1'($urandom_range(0, 1));
      end else begin
        start = chain; sel_i = chain_sel;
      end
      hold = hold_arr[t]; o_ready = rdy_arr[t]; abort = 0;
      @(negedge clk);
      exp_v = {e_clear[t], e_load[t], e_ov[t], e_run[t], e_ir[t], e_sel[t], 1'(e_part[t])};
      obs_v = {clear, load, o_valid, run, i_ready, sel, part};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL job_cycle t=%0d {clr,ld,ov,run,rdy,sel,part} got=%b want=%b", t, obs_v, exp_v);
      end
      if (o_valid === 1'b1 && first_valid < 0) first_valid = t;
`ifdef HUB_FOLD_SEQ_PERF_EN
      if (t == t_done) begin
        n_cmp++;
        if (perf_cyc !== 32'(t_done - 1)) begin
          n_fail++;
          $display("[TB] FAIL perf_cyc got=%0d want=%0d", perf_cyc, t_done - 1);
        end
      end
`endif
    end
    cur_sel = s; cur_part = FOLD_A - 1;
    @(posedge clk); #1;
    start = 0; hold = 0; o_ready = 0;
  endtask

  task automatic clear_pattern(input bit rdy);
    for (int i = 0; i < NT; i++) begin
      hold_arr[i] = 0; rdy_arr[i] = rdy;
    end
  endtask

  task automatic test_reset;
    rst = 1; start = 0; start1 = 0; sel_i = 0; hold = 0; abort = 0; o_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({clear, load, o_valid, run, i_ready, sel, part} !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_hold got=%b want=%b", {clear, load, o_valid, run, i_ready, sel, part}, 7'b0);
    end
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    n_cmp++;
    if ({clear, load, o_valid, run, i_ready, sel, part} !== 7'b0000100) begin
      n_fail++;
      $display("[TB] FAIL reset_release got=%b want=%b", {clear, load, o_valid, run, i_ready, sel, part}, 7'b0000100);
    end
    n_cmp++;
    if ({clear1, load1, o_valid1, run1, i_ready1, sel1, part1} !== 7'b0000100) begin
      n_fail++;
      $display("[TB] FAIL reset_release_fold1 got=%b want=%b", {clear1, load1, o_valid1, run1, i_ready1, sel1, part1}, 7'b0000100);
    end
`ifdef HUB_FOLD_SEQ_PERF_EN
    n_cmp++;
    if (perf_cyc !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_perf got=%0d want=0", perf_cyc);
    end
`endif
    cur_sel = 0; cur_part = 0;
  endtask

  task automatic test_basic;
    clear_pattern(1);
    run_job(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (first_valid !== 2 + FOLD_A * (CLEN_A + 1)) begin
      n_fail++;
      $display("[TB] FAIL basic_valid_latency got=%0d want=%0d", first_valid, 2 + FOLD_A * (CLEN_A + 1));
    end
  endtask

  task automatic test_hold;
    clear_pattern(1);
    hold_arr[8] = 1; hold_arr[9] = 1; hold_arr[10] = 1;
    run_job(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (first_valid !== 15) begin
      n_fail++;
      $display("[TB] FAIL hold_valid_latency got=%0d want=15", first_valid);
    end
  endtask

  task automatic test_ready_backpressure;
    clear_pattern(1);
    for (int i = 12; i <= 16; i++) rdy_arr[i] = 0;
    run_job(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (t_idle !== 18) begin
      n_fail++;
      $display("[TB] FAIL backpressure_release got=%0d want=18", t_idle);
    end
  endtask

  task automatic test_back_to_back;
    clear_pattern(1);
    run_job(1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({clear, i_ready, sel, part} !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL back_to_back_accept got=%b want=%b", {clear, i_ready, sel, part}, 4'b1000);
    end
    @(posedge clk); #1; abort = 1;
    @(posedge clk); #1; abort = 0;
    @(negedge clk);
    n_cmp++;
    if ({load, i_ready} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL back_to_back_cleanup got=%b want=01", {load, i_ready});
    end
    cur_sel = 0; cur_part = 0;
  endtask

  task automatic test_abort;
    bit saw_valid = 0;
    for (int t = 0; t <= 12; t++) begin
      @(posedge clk); #1;
      start = (t == 0) || (t == 11);
      sel_i = (t == 0);
      hold = 0; o_ready = 1; abort = (t == 9);
      @(negedge clk);
      if (o_valid !== 1'b0) saw_valid = 1;
      if (t == 9) begin
        n_cmp++;
        if ({load, run, part} !== 3'b011) begin
          n_fail++;
          $display("[TB] FAIL abort_in_run got=%b want=011", {load, run, part});
        end
      end
      if (t == 10) begin
        n_cmp++;
        if ({clear, load, o_valid, run, i_ready} !== 5'b00001) begin
          n_fail++;
          $display("[TB] FAIL abort_to_idle got=%b want=00001", {clear, load, o_valid, run, i_ready});
        end
      end
      if (t == 12) begin
        n_cmp++;
        if ({clear, i_ready, sel, part} !== 4'b1000) begin
          n_fail++;
          $display("[TB] FAIL abort_restart got=%b want=1000", {clear, i_ready, sel, part});
        end
      end
    end
    n_cmp++;
    if (saw_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_no_valid got=%b want=0", saw_valid);
    end
    @(posedge clk); #1; start = 0; abort = 1;
    @(posedge clk); #1; abort = 0;
    @(negedge clk);
    n_cmp++;
    if (i_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL abort_cleanup got=%b want=1", i_ready);
    end
    cur_sel = 0; cur_part = 0;
  endtask

  task automatic test_reset_mid_load;
    for (int t = 0; t <= 3; t++) begin
      @(posedge clk); #1;
      start = (t == 0); sel_i = (t == 0);
      hold = 0; o_ready = 0; abort = 0; rst = (t == 2);
      @(negedge clk);
      if (t == 2) begin
        n_cmp++;
        if ({load, sel, i_ready, run} !== 4'b1100) begin
          n_fail++;
          $display("[TB] FAIL rst_in_load got=%b want=1100", {load, sel, i_ready, run});
        end
      end
      if (t == 3) begin
        n_cmp++;
        if ({clear, load, o_valid, run, i_ready, sel, part} !== 7'b0000100) begin
          n_fail++;
          $display("[TB] FAIL rst_after_load got=%b want=0000100", {clear, load, o_valid, run, i_ready, sel, part});
        end
      end
    end
    @(posedge clk); #1; start = 0;
    cur_sel = 0; cur_part = 0;
  endtask

  task automatic test_fold1;
    logic [6:0] exp_v, obs_v;
    for (int t = 0; t <= 5; t++) begin
      @(posedge clk); #1;
      start1 = (t == 0); sel_i = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      hold = 0; abort = 0; o_ready = (t >= 4);
      @(negedge clk);
      exp_v = {t == 1, t == 2, t == 4, t == 3, (t == 0) || (t == 5), t != 0, 1'b0};
      obs_v = {clear1, load1, o_valid1, run1, i_ready1, sel1, part1};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL fold1_cycle t=%0d got=%b want=%b", t, obs_v, exp_v);
      end
`ifdef HUB_FOLD_SEQ_PERF_EN
      if (t == 4) begin
        n_cmp++;
        if (perf_cyc1 !== 32'd3) begin
          n_fail++;
          $display("[TB] FAIL fold1_perf got=%0d want=3", perf_cyc1);
        end
      end
`endif
    end
    @(posedge clk); #1; o_ready = 0; start1 = 0;
  endtask

  task automatic test_random;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < NT; i++) begin
        hold_arr[i] = (i < 60) && ($urandom_range(0, 3) == 0);
        rdy_arr[i]  = (i >= 80) || ($urandom_range(0, 2) == 0);
      end
      run_job(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_ready_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_mid_load();
    test_fold1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
